// File: rtl/sobrepor_caixa_pkg.sv
// sobrepor_caixa_pkg: shared widths, coordinate limits and FSM states
// for the bounding-box overlay and the pattern detector feeding it.
package sobrepor_caixa_pkg;

  localparam int CW   = 13;
  localparam int RGBW = 10;
  localparam int CNTW = 8;

  localparam int H_MAX_DEF = 800;
  localparam int V_MAX_DEF = 600;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } estado_t;

  typedef struct packed {
    logic [CW-1:0] x1;
    logic [CW-1:0] x2;
    logic [CW-1:0] y1;
    logic [CW-1:0] y2;
  } caixa_t;

endpackage

// File: rtl/sobrepor_caixa_teste_borda.sv
// sobrepor_caixa_teste_borda: combinational border hit test.
// In: H_Cont/V_Cont, shadow box caixa. Out: hit when on a BORDA-wide edge.
module sobrepor_caixa_teste_borda
  import sobrepor_caixa_pkg::*;
#(
  parameter int BORDA = 2
) (
  input  logic [CW-1:0] H_Cont,
  input  logic [CW-1:0] V_Cont,
  input  caixa_t        caixa,
  output logic          hit
);

  localparam logic [CW-1:0] B = CW'(BORDA);

  logic          dentro;
  logic [CW-1:0] d_esq;
  logic [CW-1:0] d_dir;
  logic [CW-1:0] d_cim;
  logic [CW-1:0] d_bai;

  assign dentro = (H_Cont >= caixa.x1) && (H_Cont <= caixa.x2) &&
                  (V_Cont >= caixa.y1) && (V_Cont <= caixa.y2);

  // Only meaningful when dentro is set; gated below so wrap is harmless.
  assign d_esq = H_Cont - caixa.x1;
  assign d_dir = caixa.x2 - H_Cont;
  assign d_cim = V_Cont - caixa.y1;
  assign d_bai = caixa.y2 - V_Cont;

  assign hit = dentro &&
               ((d_esq < B) || (d_dir < B) ||
                (d_cim < B) || (d_bai < B));

endmodule

// File: rtl/sobrepor_caixa.sv
// sobrepor_caixa: latches detector box at frame start, draws its border
// on the RGB stream (1-cycle latency), holds it PERSIST frames after loss.
module sobrepor_caixa
  import sobrepor_caixa_pkg::*;
#(
  parameter int              BORDA   = 2,
  parameter int              PERSIST = 15,
  parameter int              H_MAX   = H_MAX_DEF,
  parameter int              V_MAX   = V_MAX_DEF,
  parameter logic [RGBW-1:0] COR_R   = 10'h3FF,
  parameter logic [RGBW-1:0] COR_G   = 10'h000,
  parameter logic [RGBW-1:0] COR_B   = 10'h000
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [CW-1:0]   H_Cont,
  input  logic [CW-1:0]   V_Cont,
  input  logic [CW-1:0]   x1,
  input  logic [CW-1:0]   x2,
  input  logic [CW-1:0]   y1,
  input  logic [CW-1:0]   y2,
  input  logic            ativo,
  input  logic [RGBW-1:0] iRed,
  input  logic [RGBW-1:0] iGreen,
  input  logic [RGBW-1:0] iBlue,
  output logic [RGBW-1:0] oRed,
  output logic [RGBW-1:0] oGreen,
  output logic [RGBW-1:0] oBlue,
  output logic            oDesenhando,
  output logic            oCaixaInvalida
);

  localparam logic [CW-1:0]   HM      = CW'(H_MAX);
  localparam logic [CW-1:0]   VM      = CW'(V_MAX);
  localparam logic [CW-1:0]   HLIM    = CW'(H_MAX - 1);
  localparam logic [CW-1:0]   VLIM    = CW'(V_MAX - 1);
  localparam logic [CNTW-1:0] CNT_INI = CNTW'(PERSIST - 1);

  logic          fs;
  logic          geo_ok;
  logic          valido;
  logic          hit;
  logic [CW-1:0] x2c;
  logic [CW-1:0] y2c;
  caixa_t        amostra;
  caixa_t        caixa;
  estado_t       estado;
  logic [CNTW-1:0] cnt;

  assign fs  = (H_Cont == '0) && (V_Cont == '0);
  assign x2c = (x2 > HLIM) ? HLIM : x2;
  assign y2c = (y2 > VLIM) ? VLIM : y2;

  assign geo_ok = (x1 < x2c) && (y1 < y2c) &&
                  (x1 < HM) && (y1 < VM);
  assign valido = ativo && geo_ok;
  assign amostra = {x1, x2c, y1, y2c};

  sobrepor_caixa_teste_borda #(
    .BORDA(BORDA)
  ) u_borda (
    .H_Cont(H_Cont),
    .V_Cont(V_Cont),
    .caixa (caixa),
    .hit   (hit)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      oRed           <= '0;
      oGreen         <= '0;
      oBlue          <= '0;
      oDesenhando    <= 1'b0;
      oCaixaInvalida <= 1'b0;
      caixa          <= '0;
      estado         <= IDLE;
      cnt            <= '0;
    end else begin
      oCaixaInvalida <= fs && ativo && !geo_ok;

      // Hit uses the shadow/state from before this edge, so the FS
      // pixel still sees the old box.
      if (hit && oDesenhando) begin
        oRed   <= COR_R;
        oGreen <= COR_G;
        oBlue  <= COR_B;
      end else begin
        oRed   <= iRed;
        oGreen <= iGreen;
        oBlue  <= iBlue;
      end

      if (fs) begin
        unique case (estado)
          IDLE: begin
            if (valido) begin
              caixa       <= amostra;
              estado      <= SHOW;
              oDesenhando <= 1'b1;
            end
          end
          SHOW: begin
            if (valido) begin
              caixa <= amostra;
            end else if (PERSIST == 0) begin
              estado      <= IDLE;
              oDesenhando <= 1'b0;
            end else begin
              estado <= HOLD;
              cnt    <= CNT_INI;
            end
          end
          HOLD: begin
            if (valido) begin
              caixa  <= amostra;
              estado <= SHOW;
            end else if (cnt == '0) begin
              estado      <= IDLE;
              oDesenhando <= 1'b0;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          default: begin
            estado      <= IDLE;
            oDesenhando <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobrepor_caixa.sv
// tb_sobrepor_caixa: directed vectors for the box overlay, coordinates
// driven directly (frame start = one cycle at H=0,V=0).
module tb_sobrepor_caixa;

  localparam logic [29:0] COR = {10'h3FF, 10'h000, 10'h000};
  localparam logic [29:0] PIX = {10'h155, 10'h0AA, 10'h2CC};

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [12:0] H_Cont = '0;
  logic [12:0] V_Cont = '0;
  logic [12:0] x1 = '0;
  logic [12:0] x2 = '0;
  logic [12:0] y1 = '0;
  logic [12:0] y2 = '0;
  logic        ativo = 1'b0;
  logic [9:0]  iRed;
  logic [9:0]  iGreen;
  logic [9:0]  iBlue;
  logic [9:0]  oRed;
  logic [9:0]  oGreen;
  logic [9:0]  oBlue;
  logic        oDesenhando;
  logic        oCaixaInvalida;

  int n_vec = 0;
  int n_bad = 0;

  assign {iRed, iGreen, iBlue} = PIX;

  sobrepor_caixa #(
    .BORDA  (2),
    .PERSIST(3)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .H_Cont        (H_Cont),
    .V_Cont        (V_Cont),
    .x1            (x1),
    .x2            (x2),
    .y1            (y1),
    .y2            (y2),
    .ativo         (ativo),
    .iRed          (iRed),
    .iGreen        (iGreen),
    .iBlue         (iBlue),
    .oRed          (oRed),
    .oGreen        (oGreen),
    .oBlue         (oBlue),
    .oDesenhando   (oDesenhando),
    .oCaixaInvalida(oCaixaInvalida)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int h, input int v);
    H_Cont = 13'(h);
    V_Cont = 13'(v);
    @(posedge Clk);
    #1;
  endtask

  task automatic fs();
    step(0, 0);
  endtask

  task automatic set_box(input int a, input int b,
                         input int c, input int d,
                         input logic at);
    x1 = 13'(a);
    x2 = 13'(b);
    y1 = 13'(c);
    y2 = 13'(d);
    ativo = at;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    set_box(0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    n_vec++;
    if ({oRed, oGreen, oBlue} !== 30'h0) begin
      n_bad++;
      $display("FAIL reset_rgb got %h want 0", {oRed, oGreen, oBlue});
    end
    n_vec++;
    if (oDesenhando !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_desenhando got %b want 0", oDesenhando);
    end
    n_vec++;
    if (oCaixaInvalida !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_invalida got %b want 0", oCaixaInvalida);
    end
    Rst = 1'b1;
    fs();
    n_vec++;
    if (oDesenhando !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_desenhando got %b want 0", oDesenhando);
    end
    step(100, 50);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== PIX) begin
      n_bad++;
      $display("FAIL idle_pass got %h want %h", {oRed, oGreen, oBlue}, PIX);
    end
  endtask

  task automatic test_valid_box();
    int t[8][3] = '{'{100, 50, 1}, '{101, 80, 1}, '{200, 119, 1},
                    '{150, 80, 0}, '{102, 52, 0}, '{99, 50, 0},
                    '{150, 119, 1}, '{201, 80, 0}};
    set_box(100, 200, 50, 120, 1'b1);
    fs();
    n_vec++;
    if (oDesenhando !== 1'b1) begin
      n_bad++;
      $display("FAIL valid_desenhando got %b want 1", oDesenhando);
    end
    n_vec++;
    if (oCaixaInvalida !== 1'b0) begin
      n_bad++;
      $display("FAIL valid_invalida got %b want 0", oCaixaInvalida);
    end
    for (int i = 0; i < 8; i++) begin
      step(t[i][0], t[i][1]);
      n_vec++;
      if ({oRed, oGreen, oBlue} !== (t[i][2] != 0 ? COR : PIX)) begin
        n_bad++;
        $display("FAIL valid_pix(%0d,%0d) got %h want %h", t[i][0],
                 t[i][1], {oRed, oGreen, oBlue},
                 (t[i][2] != 0 ? COR : PIX));
      end
    end
  endtask

  task automatic test_mid_frame();
    int a[2][3] = '{'{100, 60, 1}, '{300, 60, 0}};
    int b[3][3] = '{'{300, 60, 1}, '{100, 60, 0}, '{400, 120, 1}};
    set_box(300, 400, 50, 120, 1'b1);
    step(150, 200);
    for (int i = 0; i < 2; i++) begin
      step(a[i][0], a[i][1]);
      n_vec++;
      if ({oRed, oGreen, oBlue} !== (a[i][2] != 0 ? COR : PIX)) begin
        n_bad++;
        $display("FAIL mid_old(%0d,%0d) got %h want %h", a[i][0],
                 a[i][1], {oRed, oGreen, oBlue},
                 (a[i][2] != 0 ? COR : PIX));
      end
    end
    fs();
    for (int i = 0; i < 3; i++) begin
      step(b[i][0], b[i][1]);
      n_vec++;
      if ({oRed, oGreen, oBlue} !== (b[i][2] != 0 ? COR : PIX)) begin
        n_bad++;
        $display("FAIL mid_new(%0d,%0d) got %h want %h", b[i][0],
                 b[i][1], {oRed, oGreen, oBlue},
                 (b[i][2] != 0 ? COR : PIX));
      end
    end
  endtask

  task automatic test_persist();
    ativo = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      fs();
      n_vec++;
      if (oDesenhando !== 1'b1) begin
        n_bad++;
        $display("FAIL hold%0d_desenhando got %b want 1", k, oDesenhando);
      end
      step(300, 60);
      n_vec++;
      if ({oRed, oGreen, oBlue} !== COR) begin
        n_bad++;
        $display("FAIL hold%0d_pix got %h want %h", k,
                 {oRed, oGreen, oBlue}, COR);
      end
    end
    fs();
    n_vec++;
    if (oDesenhando !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_end_desenhando got %b want 0", oDesenhando);
    end
    step(300, 60);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== PIX) begin
      n_bad++;
      $display("FAIL hold_end_pix got %h want %h", {oRed, oGreen, oBlue}, PIX);
    end
    ativo = 1'b1;
    fs();
    ativo = 1'b0;
    fs();
    n_vec++;
    if (oDesenhando !== 1'b1) begin
      n_bad++;
      $display("FAIL rehold_desenhando got %b want 1", oDesenhando);
    end
    set_box(500, 600, 10, 20, 1'b1);
    step(300, 60);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== COR) begin
      n_bad++;
      $display("FAIL rehold_pix got %h want %h", {oRed, oGreen, oBlue}, COR);
    end
    fs();
    step(500, 10);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== COR) begin
      n_bad++;
      $display("FAIL reshow_new got %h want %h", {oRed, oGreen, oBlue}, COR);
    end
    step(300, 60);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== PIX) begin
      n_bad++;
      $display("FAIL reshow_old got %h want %h", {oRed, oGreen, oBlue}, PIX);
    end
  endtask

  task automatic test_invalid();
    int t[5][3] = '{'{798, 150, 1}, '{799, 150, 1}, '{797, 150, 0},
                    '{800, 150, 0}, '{750, 100, 1}};
    ativo = 1'b0;
    repeat (4) fs();
    set_box(200, 100, 10, 20, 1'b1);
    fs();
    n_vec++;
    if (oCaixaInvalida !== 1'b1) begin
      n_bad++;
      $display("FAIL inv_pulse got %b want 1", oCaixaInvalida);
    end
    n_vec++;
    if (oDesenhando !== 1'b0) begin
      n_bad++;
      $display("FAIL inv_desenhando got %b want 0", oDesenhando);
    end
    step(150, 15);
    n_vec++;
    if (oCaixaInvalida !== 1'b0) begin
      n_bad++;
      $display("FAIL inv_pulse_end got %b want 0", oCaixaInvalida);
    end
    n_vec++;
    if ({oRed, oGreen, oBlue} !== PIX) begin
      n_bad++;
      $display("FAIL inv_pix got %h want %h", {oRed, oGreen, oBlue}, PIX);
    end
    set_box(700, 1000, 100, 200, 1'b1);
    fs();
    n_vec++;
    if ({oCaixaInvalida, oDesenhando} !== 2'b01) begin
      n_bad++;
      $display("FAIL clip_flags got %b want 01", {oCaixaInvalida, oDesenhando});
    end
    for (int i = 0; i < 5; i++) begin
      step(t[i][0], t[i][1]);
      n_vec++;
      if ({oRed, oGreen, oBlue} !== (t[i][2] != 0 ? COR : PIX)) begin
        n_bad++;
        $display("FAIL clip_pix(%0d,%0d) got %h want %h", t[i][0],
                 t[i][1], {oRed, oGreen, oBlue},
                 (t[i][2] != 0 ? COR : PIX));
      end
    end
  endtask

  task automatic test_tiny();
    set_box(10, 12, 10, 12, 1'b1);
    fs();
    for (int v = 10; v <= 12; v++) begin
      for (int h = 10; h <= 12; h++) begin
        step(h, v);
        n_vec++;
        if ({oRed, oGreen, oBlue} !== COR) begin
          n_bad++;
          $display("FAIL tiny(%0d,%0d) got %h want %h", h, v,
                   {oRed, oGreen, oBlue}, COR);
        end
      end
    end
    step(9, 10);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== PIX) begin
      n_bad++;
      $display("FAIL tiny(9,10) got %h want %h", {oRed, oGreen, oBlue}, PIX);
    end
    step(13, 10);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== PIX) begin
      n_bad++;
      $display("FAIL tiny(13,10) got %h want %h", {oRed, oGreen, oBlue}, PIX);
    end
  endtask

  task automatic test_reset_mid();
    step(11, 11);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== COR) begin
      n_bad++;
      $display("FAIL rmid_pre got %h want %h", {oRed, oGreen, oBlue}, COR);
    end
    H_Cont = 13'd10;
    V_Cont = 13'd300;
    Rst = 1'b0;
    #1;
    n_vec++;
    if ({oRed, oGreen, oBlue, oDesenhando} !== 31'h0) begin
      n_bad++;
      $display("FAIL rmid_async got %h want 0",
               {oRed, oGreen, oBlue, oDesenhando});
    end
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    ativo = 1'b0;
    fs();
    n_vec++;
    if (oDesenhando !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_desenhando got %b want 0", oDesenhando);
    end
    step(11, 11);
    n_vec++;
    if ({oRed, oGreen, oBlue} !== PIX) begin
      n_bad++;
      $display("FAIL rmid_pix got %h want %h", {oRed, oGreen, oBlue}, PIX);
    end
  endtask

  initial begin
    test_reset();
    test_valid_box();
    test_mid_frame();
    test_persist();
    test_invalid();
    test_tiny();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sobrepor_caixa.md
Name: sobrepor_caixa

Overview:
- Consumer of the bounding-box interface (x1, x2, y1, y2, ativo) driven by the pattern detector.
- Latches the box once per frame and draws a rectangular border of configurable colour and thickness onto the VGA pixel stream.
- Holds the last valid box for a configurable number of frames after detection drops, so the marker does not flicker.
- Sits between the colour pipeline and the VGA controller, using the same H_Cont/V_Cont counters as the detector.

Parameters:
- BORDA, 2, border thickness in pixels (1..8)
- PERSIST, 15, frames the box stays drawn after ativo falls (0..255)
- H_MAX, 800, horizontal coordinate limit; boxes are clipped to H_MAX-1
- V_MAX, 600, vertical coordinate limit; boxes are clipped to V_MAX-1
- COR_R / COR_G / COR_B, 10'h3FF / 10'h000 / 10'h000, border colour (10-bit per channel)

Ports:
- Clk  in  1  pixel clock
- Rst  in  1  asynchronous active-low reset
- H_Cont  in  13  current horizontal pixel coordinate
- V_Cont  in  13  current vertical pixel coordinate
- x1, x2, y1, y2  in  13 each  box corners from detector (x1,y1 top-left)
- ativo  in  1  detector box-valid flag
- iRed, iGreen, iBlue  in  10 each  incoming pixel colour
- oRed, oGreen, oBlue  out  10 each  outgoing pixel colour
- oDesenhando  out  1  high while a box is being displayed this frame
- oCaixaInvalida  out  1  one-cycle pulse when a frame-start sample is rejected

Behaviour:
- Reset: all outputs 0; shadow box (bx1,bx2,by1,by2) = 0; state IDLE; frame counter 0.
- Frame start (FS) is the cycle with H_Cont==0 && V_Cont==0. Box inputs are sampled only at FS; mid-frame changes have no effect (no tearing).
- Validity at FS: ativo==1 && x1<x2 && y1<y2 && x1<H_MAX && y1<V_MAX.
  - x2 and y2 are clipped to H_MAX-1 and V_MAX-1 before comparison and storage.
  - ativo==1 with invalid geometry: oCaixaInvalida pulses for 1 cycle; the sample is treated as ativo==0.
- States change only at FS:
  - IDLE: on valid sample, load shadow and go to SHOW; otherwise stay.
  - SHOW: on valid sample, reload shadow and stay. On no valid sample: if PERSIST==0 go to IDLE, else go to HOLD with counter=PERSIST-1 and shadow kept.
  - HOLD: on valid sample, reload shadow and go to SHOW. Else if counter==0 go to IDLE. Else decrement counter.
- oDesenhando = 1 in SHOW or HOLD. It is registered, so it updates the cycle after FS.
- Border hit for the current H_Cont/V_Cont:
  - The point must lie inside [bx1,bx2]×[by1,by2], inclusive on all edges.
  - It must also satisfy (H_Cont-bx1<BORDA) || (bx2-H_Cont<BORDA) || (V_Cont-by1<BORDA) || (by2-V_Cont<BORDA).
  - Subtractions use 13-bit unsigned arithmetic and are evaluated only inside the rectangle, so they cannot underflow.
- Boxes narrower than 2*BORDA render as a solid fill. This is correct behaviour.
- Pixel path latency is exactly 1 cycle: oRGB(t+1) = hit(t) && oDesenhando(t) ? COR : iRGB(t). Downstream sync must be delayed by 1 cycle externally.
- The FS cycle uses the old shadow/state for the hit test and the new shadow from FS+1 onward.
- Reset mid-frame: outputs go to 0 immediately; drawing resumes no earlier than the next FS with a valid sample.

Decomposition:
- Shared package holds:
  - coordinate width constant (13)
  - colour width (10)
  - state encoding (IDLE, SHOW, HOLD)
  - H_MAX/V_MAX defaults, shared with the detector
- One natural sub-module, teste_borda: combinational hit test taking H_Cont, V_Cont, shadow box and BORDA and returning hit.
- FSM, shadow registers and pixel mux stay in the top module.

Test Plan:
- Valid box x1=100,x2=200,y1=50,y2=120, ativo=1 at FS, iRGB=0x155 → next frame oRed=0x3FF at (100,50), (101,80), (200,119); pixel (150,80) passes 0x155 one cycle later; oDesenhando=1.
- Box inputs change to x1=300 mid-frame (V_Cont=200) → current frame still draws at x=100; new box appears only after the next FS.
- ativo drops after SHOW, PERSIST=3 → box drawn for 3 more frames, IDLE at 4th FS, oDesenhando falls one cycle after that FS; ativo reasserted during HOLD → returns to SHOW with the new coordinates.
- x1=200,x2=100, ativo=1 at FS → oCaixaInvalida pulses 1 cycle, state unchanged; x2=1000 with H_MAX=800 → clipped to 799, border drawn at column 798/799 with BORDA=2.
- Tiny box x1=10,x2=12,y1=10,y2=12, BORDA=2 → all 9 pixels coloured; pixels (9,10) and (13,10) untouched.
- Assert Rst low at V_Cont=300 while in SHOW → oRGB=0 and oDesenhando=0 immediately; after release with ativo=0 at FS, no drawing.
